// File: rtl/fir_capture_if.sv
// fir_capture_if: valid/ready stream carrying captured samples to the readout consumer.
interface fir_capture_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;
    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/fir_capture.sv
// fir_capture: triggered circular capture of FIR samples, streamed out in time order.
module fir_capture #(
    parameter int DEPTH = 256,
    parameter int PRE   = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [7:0]   x,
    input  logic                sample_en,
    input  logic signed [7:0]   trig_level,
    input  logic                arm,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       trig_addr,
    fir_capture_if.master       rd
);
    typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST, READOUT} state_t;
    localparam logic [AW-1:0] POST_N = AW'(DEPTH - PRE - 1);
    state_t state, state_n;
    logic [7:0] mem [DEPTH];
    logic [7:0] q;
    logic [AW-1:0] wp, pre_cnt, post_cnt, rd_addr;
    logic [AW:0] rd_idx;
    logic signed [7:0] prev;
    logic prev_valid, accept, trig, last_xfer, s1_valid, s1_last, s2_load, rd_en;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        state_n   = state;
        accept    = sample_en && !abort && (state == PRE_FILL || state == WAIT_TRIG || state == POST);
        trig      = accept && state == WAIT_TRIG && prev_valid && prev < trig_level && x >= trig_level;
        last_xfer = rd.valid && rd.ready && rd.last;
        case (state)
            IDLE:      state_n = arm ? PRE_FILL : IDLE;
            PRE_FILL:  state_n = accept && pre_cnt == AW'(PRE - 1) ? WAIT_TRIG : PRE_FILL;
            WAIT_TRIG: state_n = !trig ? WAIT_TRIG : POST_N == '0 ? READOUT : POST;
            POST:      state_n = accept && post_cnt == AW'(1) ? READOUT : POST;
            READOUT:   state_n = last_xfer ? IDLE : READOUT;
            default:   state_n = IDLE;
        endcase
        if (abort)
            state_n = IDLE;
    end
    // Two-stage read pipeline: the RAM output register holds while the output register is stalled.
    always_comb begin
        s2_load = s1_valid && (!rd.valid || rd.ready);
        rd_en   = state == READOUT && !rd_idx[AW] && (!s1_valid || s2_load);
        rd_addr = trig_addr - AW'(PRE) + rd_idx[AW-1:0];
    end
    always_ff @(posedge clk) begin
        if (accept)
            mem[wp] <= x;
        if (rd_en)
            q <= mem[rd_addr];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            wp         <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            trig_addr  <= '0;
            rd_idx     <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            rd.valid   <= 1'b0;
            rd.last    <= 1'b0;
            rd.data    <= '0;
        end else begin
            busy <= state_n inside {PRE_FILL, WAIT_TRIG, POST};
            done <= state_n == READOUT;
            if (state == IDLE && arm && !abort) begin
                wp         <= '0;
                pre_cnt    <= '0;
                prev_valid <= 1'b0;
            end
            if (accept) begin
                wp         <= wp + 1'b1;
                prev       <= x;
                prev_valid <= 1'b1;
            end
            if (accept && state == PRE_FILL)
                pre_cnt <= pre_cnt + 1'b1;
            if (trig) begin
                trig_addr <= wp;
                post_cnt  <= POST_N;
            end else if (accept && state == POST)
                post_cnt <= post_cnt - 1'b1;
            rd_idx <= state == READOUT && !abort ? rd_idx + (AW+1)'(rd_en) : '0;
            if (abort)
                s1_valid <= 1'b0;
            else if (rd_en) begin
                s1_valid <= 1'b1;
                s1_last  <= rd_idx == (AW+1)'(DEPTH - 1);
            end else if (s2_load)
                s1_valid <= 1'b0;
            if (abort) begin
                rd.valid <= 1'b0;
                rd.last  <= 1'b0;
            end else if (s2_load) begin
                rd.valid <= 1'b1;
                rd.last  <= s1_last;
                rd.data  <= q;
            end else if (rd.ready) begin
                rd.valid <= 1'b0;
                rd.last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_capture.sv
// tb_fir_capture: randomized capture runs checked against a sample-history window model.
module tb_fir_capture;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    logic clk = 1'b0;
    logic rst, sample_en, arm, abort, busy, done;
    logic signed [7:0] x, trig_level;
    logic [3:0] trig_addr;
    int checks = 0;
    int errors = 0;
    int sx[$];
    int lvl;
    fir_capture_if rd_if ();
    fir_capture #(.DEPTH(DEPTH), .PRE(PRE)) dut (
        .clk(clk), .rst(rst), .x(x), .sample_en(sample_en), .trig_level(trig_level),
        .arm(arm), .abort(abort), .busy(busy), .done(done), .trig_addr(trig_addr), .rd(rd_if)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask
    // Model: the window is the accepted-sample history around the first rising crossing seen after PRE samples.
    task automatic capture(input int ready_pct, input int en_mode, input int rst_after);
        int hist[$];
        int trig_i = -1;
        int k = 0;
        int c = 0;
        int got = 0;
        int held_d = 0;
        int held_l = 0;
        bit complete = 0;
        bit stalled = 0;
        bit en, rdy;
        trig_level = 8'(lvl);
        arm = 1'b1;
        step;
        arm = 1'b0;
        chk("busy_after_arm", busy, 1);
        while (!complete && k < sx.size() && c < 2000) begin
            en = en_mode == 0 ? 1'b1 : en_mode == 1 ? c[0] == 1'b0 : 1'($urandom_range(0, 1));
            sample_en = en;
            x = en ? 8'(sx[k]) : 8'($urandom);
            if (en) begin
                hist.push_back(sx[k]);
                k++;
                if (trig_i < 0 && hist.size() > PRE && hist[hist.size()-2] < lvl && hist[hist.size()-1] >= lvl)
                    trig_i = hist.size() - 1;
                complete = trig_i >= 0 && hist.size() == trig_i + DEPTH - PRE;
            end
            step;
            c++;
            if (rst_after >= 0 && trig_i >= 0 && hist.size() == trig_i + 1 + rst_after) begin
                rst = 1'b1;
                sample_en = 1'b0;
                step;
                rst = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_valid", rd_if.valid, 0);
                chk("rst_last", rd_if.last, 0);
                chk("rst_data", rd_if.data, 0);
                chk("rst_trig_addr", trig_addr, 0);
                return;
            end
            if (!complete) begin
                chk("busy_capturing", busy, 1);
                chk("done_capturing", done, 0);
            end
        end
        sample_en = 1'b0;
        if (!complete) begin
            chk("busy_no_trig", busy, 1);
            abort = 1'b1;
            step;
            abort = 1'b0;
            chk("busy_after_abort", busy, 0);
            chk("done_after_abort", done, 0);
            return;
        end
        chk("done_at_readout", done, 1);
        chk("busy_at_readout", busy, 0);
        chk("trig_addr", trig_addr, trig_i % DEPTH);
        chk("valid_lat0", rd_if.valid, 0);
        step;
        chk("valid_lat1", rd_if.valid, 0);
        step;
        chk("valid_lat2", rd_if.valid, 1);
        c = 0;
        while (got < DEPTH && c < 2000) begin
            if (stalled) begin
                chk("stall_valid", rd_if.valid, 1);
                chk("stall_data", rd_if.data, held_d);
                chk("stall_last", rd_if.last, held_l);
            end
            rdy = $urandom_range(0, 99) < ready_pct;
            rd_if.ready = rdy;
            stalled = 0;
            if (rd_if.valid && rdy) begin
                chk("rd_data", $signed(rd_if.data), hist[trig_i - PRE + got]);
                chk("rd_last", rd_if.last, int'(got == DEPTH - 1));
                got++;
            end else if (rd_if.valid) begin
                stalled = 1;
                held_d = rd_if.data;
                held_l = rd_if.last;
            end
            step;
            c++;
        end
        rd_if.ready = 1'b0;
        chk("rd_count", got, DEPTH);
        if (ready_pct == 100)
            chk("rd_cycles", c, DEPTH);
        chk("done_after_last", done, 0);
        chk("valid_after_last", rd_if.valid, 0);
        chk("busy_after_last", busy, 0);
    endtask
    task automatic ramp(input int start, input int n);
        sx.delete();
        for (int i = 0; i < n; i++)
            sx.push_back(start + i);
    endtask
    initial begin
        rst = 1'b1;
        sample_en = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        x = '0;
        trig_level = '0;
        rd_if.ready = 1'b0;
        lvl = 0;
        step;
        step;
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_valid", rd_if.valid, 0);
        chk("reset_last", rd_if.last, 0);
        chk("reset_data", rd_if.data, 0);
        chk("reset_trig_addr", trig_addr, 0);
        ramp(-20, 60);
        capture(100, 0, -1);
        sx = '{1, 1, 1, 1, 0, 0, 10, -10, -20, -20};
        capture(100, 0, -1);
        sx.delete();
        for (int i = 0; i < 40; i++)
            sx.push_back(5);
        capture(100, 0, -1);
        sx = '{-1, -1, -1, -1, -1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        capture(100, 0, -1);
        sx.delete();
        for (int i = 0; i < 41; i++)
            sx.push_back($urandom_range(10, 100));
        sx.push_back(-5);
        sx.push_back(3);
        for (int i = 0; i < 11; i++)
            sx.push_back($urandom_range(0, 255) - 128);
        capture(100, 0, -1);
        ramp(-20, 60);
        capture(50, 0, -1);
        ramp(-20, 60);
        capture(100, 1, -1);
        ramp(-20, 60);
        capture(100, 0, 3);
        ramp(-20, 60);
        capture(100, 0, -1);
        arm = 1'b1;
        abort = 1'b1;
        step;
        arm = 1'b0;
        abort = 1'b0;
        chk("arm_abort_busy", busy, 0);
        sample_en = 1'b1;
        step;
        step;
        sample_en = 1'b0;
        chk("arm_abort_busy_later", busy, 0);
        chk("arm_abort_done", done, 0);
        for (int r = 0; r < 6; r++) begin
            lvl = $urandom_range(0, 100) - 50;
            sx.delete();
            for (int i = 0; i < 150; i++)
                sx.push_back($urandom_range(0, 255) - 128);
            capture(70, 2, -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_capture.md
# fir_capture

Triggered capture buffer downstream of the FIR stage. It stores a window of the 8-bit FIR output, centred on a rising level crossing, in an internal circular RAM. It then streams the window out in time order over a valid/ready interface, oscilloscope style, to a readout or host-interface consumer.

## Interface
- DEPTH, 256: samples per capture; power of two, 4..1024.
- PRE, 64: samples stored before the trigger sample; 1 ≤ PRE ≤ DEPTH-1.
- AW, log2(DEPTH): address width.
- clk  in  1  sample and system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- x  in  8  signed FIR output sample (upper byte of the FIR result).
- sample_en  in  1  x is a valid sample this cycle.
- trig_level  in  8  signed trigger threshold; sampled continuously.
- arm  in  1  one-cycle pulse; starts a capture from IDLE only.
- abort  in  1  return to IDLE from any state.
- busy  out  1  high in PRE_FILL, WAIT_TRIG, POST.
- done  out  1  high in READOUT.
- trig_addr  out  AW  RAM address of the trigger sample; held until next trigger.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  8  signed captured sample.
- rd_last  out  1  high with the DEPTH-th (final) sample.

## Operation
- RAM: DEPTH x 8, one write port, one synchronous read port. Write pointer wp wraps modulo DEPTH.
- States: IDLE, PRE_FILL, WAIT_TRIG, POST, READOUT.
- IDLE: arm -> PRE_FILL. Set wp=0, pre counter=0, prev_valid=0.
- Sample accept: a sample is accepted when sample_en=1 in PRE_FILL, WAIT_TRIG or POST. It is written at wp, then wp=wp+1. The register prev=x and prev_valid is set.
- PRE_FILL: counts accepted samples. After the PRE-th acceptance -> WAIT_TRIG. No trigger is evaluated here.
- WAIT_TRIG: keeps writing circularly, overwriting the oldest samples. Trigger fires on an accepted sample when prev_valid && prev < trig_level && x ≥ trig_level (signed compare).
  - On trigger, the sample is written and trig_addr=wp.
  - Post counter loads DEPTH-PRE-1.
  - If the counter is 0, go -> READOUT; otherwise -> POST.
- POST: each accepted sample decrements the counter. The acceptance that brings it to 0 -> READOUT.
- READOUT:
  - Streams DEPTH samples starting at address trig_addr-PRE (mod DEPTH), ascending with wrap.
  - Order: PRE pre-trigger samples, the trigger sample, then DEPTH-PRE-1 post-trigger samples.
  - x and sample_en are ignored.
  - After the handshake carrying rd_last -> IDLE.
- abort: -> IDLE on the next edge from any state. rd_valid, rd_last and done drop, and the partial capture is discarded. abort has priority over arm in the same cycle.
- arm outside IDLE is ignored.
- trig_addr is not cleared by abort.

## Timing
- Reset values: state IDLE; busy=0, done=0, rd_valid=0, rd_last=0, rd_data=0, trig_addr=0; wp and counters 0.
- rst mid-operation behaves like abort, plus clears trig_addr.
- busy and done are registered from state; they change on the edge that changes state.
- Trigger-to-READOUT: READOUT is entered on the edge that accepts the final post-trigger sample. With PRE=DEPTH-1 it is the trigger edge itself.
- rd_valid first rises exactly 2 cycles after entering READOUT, allowing for the RAM read plus the output register.
- Handshake: transfer occurs when rd_valid && rd_ready.
  - While rd_valid && !rd_ready, rd_data and rd_last must hold.
  - rd_valid never drops before the rd_last transfer, except on abort or rst.
- Throughput: with rd_ready held high, one sample per cycle (prefetch/skid). The full window takes DEPTH cycles after the first rd_valid.
- done falls and state returns to IDLE on the edge of the rd_last transfer. arm is accepted from the following cycle.

## Test plan
- DEPTH=16, PRE=4, trig_level=0, sample_en=1, x ramps +1/cycle from -20, arm -> readout sequence is -4,-3,...,11. rd_last is set only on 11. trig_addr is the address where 0 was written.
- Equality and falling edges: x = -1,0 triggers; x = 0,0 does not; x = 10,-10 does not. Constant x=5 with level 0 -> busy stays 1, done 0. A later abort -> busy=0 after 1 cycle.
- Wrap-around: DEPTH=16, PRE=4, 37 non-crossing samples in WAIT_TRIG, then a crossing. The readout must contain exactly the 4 samples before the trigger, in order, followed by the trigger sample and the next 11 samples.
- Backpressure: random rd_ready (50%) -> identical 16-sample sequence. rd_data is stable while stalled, and exactly 16 transfers occur. With rd_ready=1, the 16 transfers happen in 16 consecutive cycles.
- sample_en gaps: sample_en toggles 1,0,1,0. Only enabled samples are stored, and the post count counts accepted samples only.
- rst asserted mid-POST -> all outputs at reset values the next cycle. A subsequent arm completes a correct capture. arm+abort in the same cycle -> stays IDLE.
